// File: rtl/conv2d_sched.sv
`default_nettype none
// ============================================================================
// Module   : conv2d_sched
// Purpose  : Round-robin scheduler sharing one conv2d engine among NUM_REQ
//            requesters. Grants one requester at a time, pulses the engine
//            start, waits for engine completion (or a cycle-limit timeout),
//            then acknowledges the granted requester. Records the latency and
//            requester index of every job.
// Revision : 1.0 - initial release
// ----------------------------------------------------------------------------
// Ports
//   clk          in   1        rising-edge clock
//   rst          in   1        asynchronous reset, active low
//   req          in   NUM_REQ  level request per requester
//   ack          out  NUM_REQ  one-hot one-cycle completion pulse
//   err          out  1        one-cycle pulse with ack: timeout / invalid
//   grant_valid  out  1        grant held, operand mux select valid
//   grant_idx    out  IDX_W    index of the granted requester
//   eng_start    out  1        one-cycle engine start pulse
//   eng_done     in   1        engine completion
//   eng_valid    in   1        engine result valid, sampled with eng_done
//   busy         out  1        scheduler not idle
//   last_cycles  out  CYCLE_W  latency of the most recent job
//   last_idx     out  IDX_W    requester index of the most recent job
// ============================================================================
module conv2d_sched #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ),
    parameter int CYCLE_W = 16,
    parameter int TIMEOUT = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    output logic [NUM_REQ-1:0] ack,
    output logic               err,
    output logic               grant_valid,
    output logic [IDX_W-1:0]   grant_idx,
    output logic               eng_start,
    input  logic               eng_done,
    input  logic               eng_valid,
    output logic               busy,
    output logic [CYCLE_W-1:0] last_cycles,
    output logic [IDX_W-1:0]   last_idx
);

    localparam logic               TIMEOUT_EN  = (TIMEOUT != 0);
    localparam logic [CYCLE_W-1:0] TIMEOUT_CNT = CYCLE_W'(TIMEOUT);
    localparam logic [CYCLE_W-1:0] CNT_MAX     = {CYCLE_W{1'b1}};
    localparam logic [IDX_W-1:0]   IDX_LAST    = IDX_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_RUN   = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t             state;
    state_t             state_nxt;

    logic [IDX_W-1:0]   ptr;
    logic [CYCLE_W-1:0] cnt;
    logic               job_err;

    // Round-robin pick: first set request at or after ptr, wrapping around.
    logic               pick_found;
    logic [IDX_W-1:0]   pick_idx;
    logic [IDX_W-1:0]   cand;

    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = IDX_W'((int'(ptr) + i) % NUM_REQ);
            if (!pick_found && req[cand]) begin
                pick_found = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    // Terminal conditions in RUN; done takes priority over the timeout.
    logic run_done;
    logic run_timeout;

    assign run_done    = (state == S_RUN) && eng_done;
    assign run_timeout = (state == S_RUN) && !eng_done && TIMEOUT_EN &&
                         (cnt == TIMEOUT_CNT);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and state-decoded outputs
    always_comb begin
        state_nxt   = state;
        ack         = '0;
        err         = 1'b0;
        eng_start   = 1'b0;
        busy        = 1'b1;
        grant_valid = 1'b1;
        case (state)
            S_IDLE: begin
                busy        = 1'b0;
                grant_valid = 1'b0;
                if (pick_found) begin
                    state_nxt = S_START;
                end
            end
            S_START: begin
                eng_start = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                if (run_done || run_timeout) begin
                    state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                ack       = NUM_REQ'(1) << grant_idx;
                err       = job_err;
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Grant, pointer, cycle counter and job result registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ptr         <= '0;
            grant_idx   <= '0;
            cnt         <= '0;
            job_err     <= 1'b0;
            last_cycles <= '0;
            last_idx    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (pick_found) begin
                        grant_idx <= pick_idx;
                        cnt       <= '0;
                    end
                end
                S_START: begin
                    cnt <= cnt + 1'b1;
                end
                S_RUN: begin
                    if (run_done) begin
                        last_cycles <= cnt;
                        last_idx    <= grant_idx;
                        job_err     <= !eng_valid;
                    end else if (run_timeout) begin
                        last_cycles <= cnt;
                        last_idx    <= grant_idx;
                        job_err     <= 1'b1;
                    end else if (cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                S_DONE: begin
                    ptr <= (grant_idx == IDX_LAST) ? '0 : grant_idx + 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_conv2d_sched.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_conv2d_sched
// Purpose  : Self-checking bench for conv2d_sched. A requester/engine model
//            drives jobs; expected grants come from a round-robin reference
//            function and expected latency / error from the job rules.
// Revision : 1.0 - initial release
// ============================================================================
module tb_conv2d_sched;

    localparam int NR = 4;
    localparam int IW = 2;
    localparam int CW = 16;
    localparam int TO = 64;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [NR-1:0] req = '0;
    logic          eng_done = 1'b0;
    logic          eng_valid = 1'b0;
    logic [NR-1:0] ack;
    logic          err;
    logic          grant_valid;
    logic [IW-1:0] grant_idx;
    logic          eng_start;
    logic          busy;
    logic [CW-1:0] last_cycles;
    logic [IW-1:0] last_idx;

    conv2d_sched #(
        .NUM_REQ (NR),
        .IDX_W   (IW),
        .CYCLE_W (CW),
        .TIMEOUT (TO)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .req         (req),
        .ack         (ack),
        .err         (err),
        .grant_valid (grant_valid),
        .grant_idx   (grant_idx),
        .eng_start   (eng_start),
        .eng_done    (eng_done),
        .eng_valid   (eng_valid),
        .busy        (busy),
        .last_cycles (last_cycles),
        .last_idx    (last_idx)
    );

    always #5 clk = ~clk;

    int passed    = 0;
    int total     = 0;
    int exp_ptr   = 0;
    int start_cnt = 0;
    int ack_cnt   = 0;

    always @(posedge clk) begin
        if (eng_start === 1'b1) start_cnt <= start_cnt + 1;
        if (ack !== '0)         ack_cnt   <= ack_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference round-robin choice: first requester at or after p, wrapping.
    function automatic int rr_pick(input logic [NR-1:0] r, input int p);
        for (int off = 0; off < NR; off++) begin
            if (r[(p + off) % NR]) return (p + off) % NR;
        end
        return -1;
    endfunction

    task automatic check_reset(input string tag);
        check({tag, "_ack"},   32'(ack), 0);
        check({tag, "_err"},   32'(err), 0);
        check({tag, "_gv"},    32'(grant_valid), 0);
        check({tag, "_gidx"},  32'(grant_idx), 0);
        check({tag, "_start"}, 32'(eng_start), 0);
        check({tag, "_busy"},  32'(busy), 0);
        check({tag, "_lcyc"},  32'(last_cycles), 0);
        check({tag, "_lidx"},  32'(last_idx), 0);
    endtask

    // One job: k = RUN cycle in which done is raised (0 = never), v = valid.
    task automatic run_job(input int k, input bit v, input bit drop_req, output int g);
        int  waitc = 0;
        bit  seen  = 0;
        int  exp_g;
        int  n;
        bit  tout;
        while (!seen && waitc < 30) begin
            @(negedge clk);
            if (eng_start === 1'b1) seen = 1;
            else waitc++;
        end
        if (!seen) begin
            check("start_seen", 32'(eng_start), 1);
            g = -1;
            return;
        end
        exp_g = rr_pick(req, exp_ptr);
        tout  = (k == 0) || (k > TO);
        n     = tout ? TO : k;
        check("grant_idx", 32'(grant_idx), 32'(exp_g));
        check("grant_valid", 32'(grant_valid), 1);
        for (int j = 1; j <= n; j++) begin
            @(negedge clk);
            if (j == k) begin
                eng_done  = 1'b1;
                eng_valid = v;
            end else begin
                eng_done  = 1'b0;
                eng_valid = 1'($urandom_range(0, 1));
            end
        end
        @(negedge clk);
        eng_done  = 1'b0;
        eng_valid = 1'b0;
        check("ack", 32'(ack), 32'(1 << exp_g));
        check("err", 32'(err), tout ? 1 : 32'(!v));
        check("last_cycles", 32'(last_cycles), 32'(n));
        check("gidx_stable", 32'(grant_idx), 32'(exp_g));
        if (!tout) check("last_idx", 32'(last_idx), 32'(exp_g));
        exp_ptr = (exp_g + 1) % NR;
        if (drop_req) req[exp_g] = 1'b0;
        @(negedge clk);
        check("ack_one_cycle", 32'(ack), 0);
        check("idle_after", 32'(busy), 0);
        g = exp_g;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        exp_ptr = 0;
    endtask

    int g;
    int s0;
    int a0;
    logic [CW-1:0] lc_save;

    initial begin
        // Reset state
        req = '0;
        repeat (3) @(negedge clk);
        check_reset("rst");
        rst = 1'b1;
        @(negedge clk);

        // Single job on requester 2, done in the 6th RUN cycle
        s0 = start_cnt;
        req = 4'b0100;
        run_job(6, 1'b1, 1'b1, g);
        check("t1_grant", 32'(g), 2);
        repeat (3) @(negedge clk);
        check("t1_starts", 32'(start_cnt - s0), 1);

        // All four requests after reset: grants 0,1,2,3
        do_reset();
        s0 = start_cnt;
        a0 = ack_cnt;
        req = 4'b1111;
        for (int i = 0; i < NR; i++) begin
            run_job(int'($urandom_range(1, 10)), 1'b1, 1'b1, g);
            check("t2_order", 32'(g), 32'(i));
        end
        repeat (3) @(negedge clk);
        check("t2_starts", 32'(start_cnt - s0), 4);
        check("t2_acks", 32'(ack_cnt - a0), 4);

        // Requesters 0 and 3 always re-requesting: alternate 0,3,0,3
        req = 4'b1001;
        for (int i = 0; i < 4; i++) begin
            run_job(int'($urandom_range(1, 8)), 1'b1, 1'b0, g);
            check("t3_alt", 32'(g), (i % 2 == 0) ? 0 : 3);
        end
        req = '0;
        @(negedge clk);

        // Engine never completes: timeout
        req = 4'b0010;
        run_job(0, 1'b1, 1'b1, g);
        // Done in exactly the timeout cycle: done wins
        req = 4'b0010;
        run_job(TO, 1'b1, 1'b1, g);
        // Completion with invalid result
        req = 4'b1000;
        run_job(int'($urandom_range(1, 12)), 1'b0, 1'b1, g);

        // Stray eng_done while idle
        repeat (2) @(negedge clk);
        lc_save  = last_cycles;
        eng_done = 1'b1;
        eng_valid = 1'b1;
        @(negedge clk);
        eng_done = 1'b0;
        eng_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stray_ack", 32'(ack), 0);
            check("stray_busy", 32'(busy), 0);
            @(negedge clk);
        end
        check("stray_lcyc", 32'(last_cycles), 32'(lc_save));

        // Randomized jobs, some beyond the timeout
        for (int i = 0; i < 12; i++) begin
            if (req == '0) req = NR'($urandom_range(1, (1 << NR) - 1));
            run_job(int'($urandom_range(1, 70)), 1'($urandom_range(0, 1)), 1'b1, g);
        end
        req = '0;
        repeat (2) @(negedge clk);

        // Reset mid-RUN while granted to 2
        req = 4'b0100;
        begin : mid_rst
            int waitc = 0;
            while (eng_start !== 1'b1 && waitc < 30) begin
                @(negedge clk);
                waitc++;
            end
        end
        check("mr_grant", 32'(grant_idx), 2);
        repeat (3) @(negedge clk);
        check("mr_busy", 32'(busy), 1);
        rst = 1'b0;
        #1;
        check_reset("mr");
        @(negedge clk);
        req = 4'b1111;
        rst = 1'b1;
        exp_ptr = 0;
        run_job(3, 1'b1, 1'b1, g);
        check("mr_first", 32'(g), 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/conv2d_sched.md
# conv2d_sched

Round-robin scheduler that shares one `conv2d` engine among `NUM_REQ` requesters. It sits between the requester ports and the engine's `start`/`done`/`valid` handshake. It drives a grant index that the top level uses to mux operand buses (input tensor, weights, bias) into the engine. For every job it measures engine latency in cycles and flags engine timeouts and invalid completions.

## Interface
- `NUM_REQ`, 4: number of requesters, at least 2.
- `IDX_W`, `$clog2(NUM_REQ)`: width of the grant index.
- `CYCLE_W`, 16: width of the cycle counter. Must satisfy `2**CYCLE_W > TIMEOUT`.
- `TIMEOUT`, 1024: job cycle limit. 0 disables the timeout.

- `clk` input 1: clock, rising edge.
- `rst` input 1: asynchronous, active-low reset (`rst`=0 resets).
- `req` input `NUM_REQ`: level request per requester.
- `ack` output `NUM_REQ`: one-hot, one-cycle completion pulse to the granted requester.
- `err` output 1: one-cycle pulse, concurrent with `ack`, when the job timed out or completed invalid.
- `grant_valid` output 1: high from grant until job end; operand mux select is valid.
- `grant_idx` output `IDX_W`: index of the granted requester.
- `eng_start` output 1: one-cycle start pulse to the engine.
- `eng_done` input 1: engine completion.
- `eng_valid` input 1: engine result valid, sampled with `eng_done`.
- `busy` output 1: state is not IDLE.
- `last_cycles` output `CYCLE_W`: latency of the most recent job.
- `last_idx` output `IDX_W`: requester index of the most recent job.

## Operation
- FSM states: IDLE, START, RUN, DONE. All outputs are registered or decoded from state and registers.
- IDLE:
  - If any `req` bit is high, pick the first set bit searching upward from `ptr` with wrap-around.
  - Latch `grant_idx`, set `grant_valid`, clear `cnt`, go to START.
  - If no request, stay in IDLE.
- START: `eng_start`=1 for exactly this cycle; `cnt` increments; go to RUN. `eng_done` is ignored in this cycle.
- RUN:
  - If `eng_done`=1: latch `last_cycles`=`cnt`, `last_idx`=`grant_idx`, `job_err`=!`eng_valid`; go to DONE.
  - Else if `TIMEOUT`≠0 and `cnt`==`TIMEOUT`: latch `last_cycles`=`cnt`, `job_err`=1; go to DONE.
  - Else `cnt` increments, saturating at its maximum value, and the state stays RUN.
  - If `eng_done` and the timeout occur in the same cycle, done wins and `err` depends only on `eng_valid`.
- DONE:
  - `ack[grant_idx]`=1 and `err`=`job_err`, both for one cycle.
  - `ptr` ← (`grant_idx`+1) mod `NUM_REQ`.
  - Go to IDLE. `grant_valid` drops on entry to IDLE.
- Requester rules:
  - Hold `req` until `ack` is seen, then deassert it on the following edge.
  - `req` high in IDLE is treated as a new request.
  - Dropping `req` mid-job has no effect; the job completes and `ack` still pulses.
- `eng_done` while in IDLE or DONE is ignored.
- Reset at any time, including mid-RUN:
  - State returns to IDLE.
  - `ptr`=0, `cnt`=0, `job_err`=0.
  - The engine is expected to be reset by the same `rst`.

## Timing
- Reset values: `ack`=0, `err`=0, `grant_valid`=0, `grant_idx`=0, `eng_start`=0, `busy`=0, `last_cycles`=0, `last_idx`=0.
- Grant latency: `req` sampled in IDLE at edge k gives `grant_valid`=1 and `eng_start`=1 in cycle k+1 (START).
- `last_cycles` counts the START cycle plus RUN cycles in which `eng_done`=0. If done is sampled in the first RUN cycle, `last_cycles`=1.
- `ack` comes 1 cycle after `eng_done` is sampled. `last_cycles` and `last_idx` are valid in the `ack` cycle.
- Per-job overhead outside RUN is 3 cycles (START, DONE, IDLE). Minimum job-to-job spacing is 4 cycles.
- `grant_idx` is stable from START through DONE.

## Test plan
- `NUM_REQ`=4, `TIMEOUT`=64; hold `req[2]`; engine asserts `eng_done`=1, `eng_valid`=1 in the 6th RUN cycle. Required:
  - exactly one `eng_start` pulse;
  - `grant_idx`=2;
  - `ack`=4'b0100 for one cycle, `err`=0;
  - `last_cycles`=6, `last_idx`=2.
- After reset, all four `req` bits rise together. Required: grants in order 0,1,2,3, each acked once, 4 `eng_start` pulses.
- `req[0]` and `req[3]` re-assert immediately after each `ack`. Required: grants alternate 0,3,0,3 with no starvation.
- Engine never asserts done. Required: `ack` pulses after `cnt` reaches 64, with `err`=1 and `last_cycles`=64.
- Two further cases:
  - `eng_done`=1 with `eng_valid`=0 requires `err`=1 with `ack`.
  - A stray `eng_done` pulse in IDLE requires no `ack` and no state change.
- `rst`=0 asserted mid-RUN while granted to index 2. Required:
  - all outputs take reset values immediately;
  - after release, with `req`=4'b1111, the first grant is index 0.
